// File: rtl/rv_io_rom_pkg.sv
// rv_io_rom_pkg
// Shared definitions for the multi-outstanding IO ROM slave.
//   - Default configuration constants for the slave and its queue.
//   - Response entry layout {rdata, rtag, rerr} for the default widths.
//   - ROM content generator shared by the dtbrom-style lookup.
package rv_io_rom_pkg;

   localparam int RV_DEFAULT    = 64;
   localparam int TW_DEFAULT    = 4;
   localparam int DEPTH_DEFAULT = 4;

   // Byte-offset bits inside one ROM word and queue pointer index width.
   localparam int WOFF = $clog2(RV_DEFAULT / 8);
   localparam int PW   = $clog2(DEPTH_DEFAULT);

   typedef struct packed {
      logic [RV_DEFAULT-1:0] rdata;
      logic [TW_DEFAULT-1:0] rtag;
      logic                  rerr;
   } resp_t;

   localparam logic [31:0] ROM_SEED = 32'hD7B0_0000;

   // 32-bit chunk k of ROM word idx. Each word is built from RV/32 chunks,
   // chunk 0 in the least-significant position.
   function automatic logic [31:0] rom_chunk(input logic [31:0] idx,
                                             input logic [31:0] k);
      return ROM_SEED + (idx << 4) + k;
   endfunction

endpackage

// File: rtl/rv_io_rom_dtbrom.sv
// rv_io_rom_dtbrom
// Combinational device-tree style ROM: word index in, RV-bit word out.
// Ports:
//   idx   in  IW  word index
//   word  out RV  ROM word, zero for indices at or beyond ROM_WORDS
module rv_io_rom_dtbrom
   import rv_io_rom_pkg::*;
#(
   parameter int RV        = 64,
   parameter int IW        = 9,
   parameter int ROM_WORDS = 512
) (
   input  logic [IW-1:0] idx,
   output logic [RV-1:0] word
);

   localparam int          NCH   = RV / 32;
   localparam logic [IW:0] LIMIT = (IW+1)'(ROM_WORDS);

   always_comb begin
      word = '0;
      if ({1'b0, idx} < LIMIT) begin
         for (int k = 0; k < NCH; k++) begin
            word[k*32 +: 32] = rom_chunk(32'(idx), 32'(k));
         end
      end
   end

endmodule

// File: rtl/rv_io_rom_fifo.sv
// rv_io_rom_fifo
// Synchronous circular-buffer FIFO with simultaneous push/pop support.
// Ports:
//   clk, reset  clock, synchronous active-high reset (control state only)
//   push        write wdata this cycle (honoured when not full or popping)
//   pop         retire the head this cycle (ignored when empty)
//   wdata       entry to write
//   full/empty  occupancy flags
//   head        oldest entry (contents undefined when empty)
module rv_io_rom_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic [7:0]
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic pop,
   input  T     wdata,
   output logic full,
   output logic empty,
   output T     head
);

   localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
   localparam logic [PW:0] LAST    = (PW+1)'(DEPTH - 1);

   T            mem [DEPTH];
   logic [PW:0] rd_ptr;
   logic [PW:0] wr_ptr;
   logic [PW:0] count;
   logic        do_push;
   logic        do_pop;
   logic        unused_ptr_msb;

   // Pointers wrap modulo DEPTH, so their top bit only ever reads zero.
   function automatic logic [PW:0] ptr_next(input logic [PW:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot the push is about to use.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr[PW-1:0]];
   assign unused_ptr_msb = rd_ptr[PW] ^ wr_ptr[PW];

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_next(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries data only; occupancy is tracked by the control above.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
   end

endmodule

// File: rtl/rv_io_rom_mq.sv
// rv_io_rom_mq
// Multi-outstanding tagged read-only ROM slave for the multi-CPU IO switch.
// Reads are queued with their tags and returned in acceptance order.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   addr_req         switch offers a transaction
//   addr_ack         transaction accepted (combinational)
//   sel              this slave is addressed
//   addr             byte address (low WOFF bits ignored)
//   read             1 = read, 0 = write (writes are acked and dropped)
//   tag              requester tag
//   data_req         head response valid
//   data_ack         switch consumes the head response
//   rdata/rtag/rerr  head response, zero while the queue is empty
module rv_io_rom_mq
   import rv_io_rom_pkg::*;
#(
   parameter int RV        = 64,
   parameter int AW        = 12,
   parameter int ROM_WORDS = 512,
   parameter int DEPTH     = 4,
   parameter int TW        = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          addr_req,
   output logic          addr_ack,
   input  logic          sel,
   input  logic [AW-1:0] addr,
   input  logic          read,
   input  logic [TW-1:0] tag,
   output logic          data_req,
   input  logic          data_ack,
   output logic [RV-1:0] rdata,
   output logic [TW-1:0] rtag,
   output logic          rerr
);

   localparam int          BOFF  = $clog2(RV / 8);
   localparam int          IW    = AW - BOFF;
   localparam logic [IW:0] LIMIT = (IW+1)'(ROM_WORDS);

   typedef struct packed {
      logic [RV-1:0] rdata;
      logic [TW-1:0] rtag;
      logic          rerr;
   } entry_t;

   logic [IW-1:0] word_idx;
   logic [RV-1:0] rom_word;
   logic          in_range;
   logic          full;
   logic          empty;
   logic          pop;
   logic          push;
   entry_t        push_entry;
   entry_t        head;
   logic          unused_low_addr;

   assign word_idx        = addr[AW-1:BOFF];
   assign unused_low_addr = ^addr[BOFF-1:0];
   assign in_range        = ({1'b0, word_idx} < LIMIT);

   rv_io_rom_dtbrom #(
      .RV        (RV),
      .IW        (IW),
      .ROM_WORDS (ROM_WORDS)
   ) u_rom (
      .idx  (word_idx),
      .word (rom_word)
   );

   // data_req is registered state, so data_ack reaches only addr_ack here.
   assign pop      = data_req && data_ack;
   assign addr_ack = !reset && addr_req && sel && (!read || !full || pop);
   assign push     = addr_ack && read;

   always_comb begin
      push_entry       = '0;
      push_entry.rtag  = tag;
      push_entry.rerr  = !in_range;
      push_entry.rdata = in_range ? rom_word : '0;
   end

   rv_io_rom_fifo #(
      .DEPTH (DEPTH),
      .T     (entry_t)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (push_entry),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

   // Head fields are masked so an empty queue presents all-zero outputs.
   assign data_req = !empty;
   assign rdata    = empty ? '0 : head.rdata;
   assign rtag     = empty ? '0 : head.rtag;
   assign rerr     = empty ? 1'b0 : head.rerr;

endmodule

// File: tb/tb_rv_io_rom_mq.sv
module tb_rv_io_rom_mq;

   localparam int RV        = 64;
   localparam int AW        = 13;
   localparam int ROM_WORDS = 512;
   localparam int DEPTH     = 4;
   localparam int TW        = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          addr_req = 1'b0;
   logic          addr_ack;
   logic          sel = 1'b0;
   logic [AW-1:0] addr = '0;
   logic          read = 1'b0;
   logic [TW-1:0] tag = '0;
   logic          data_req;
   logic          data_ack = 1'b0;
   logic [RV-1:0] rdata;
   logic [TW-1:0] rtag;
   logic          rerr;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   rv_io_rom_mq #(
      .RV(RV), .AW(AW), .ROM_WORDS(ROM_WORDS), .DEPTH(DEPTH), .TW(TW)
   ) dut (
      .clk(clk), .reset(reset), .addr_req(addr_req), .addr_ack(addr_ack),
      .sel(sel), .addr(addr), .read(read), .tag(tag), .data_req(data_req),
      .data_ack(data_ack), .rdata(rdata), .rtag(rtag), .rerr(rerr)
   );

   // Expected ROM contents: word i is two 32-bit chunks, base+0 low, base+1 high.
   function automatic logic [63:0] rom_w(input int i);
      logic [31:0] b;
      b = 32'hD7B0_0000 + 32'(i) * 32'd16;
      return {b + 32'd1, b};
   endfunction

   typedef struct {
      logic          areq;
      logic          sel;
      logic [AW-1:0] addr;
      logic          rd;
      logic [TW-1:0] tag;
      logic          dack;
      logic          e_ack;
      logic          e_dreq;
      logic [RV-1:0] e_rdata;
      logic [TW-1:0] e_rtag;
      logic          e_rerr;
   } vec_t;

   vec_t vt[17];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic a_req, input logic s, input logic [AW-1:0] a,
                        input logic rd, input logic [TW-1:0] t, input logic dack);
      addr_req = a_req; sel = s; addr = a; read = rd; tag = t; data_ack = dack;
      #1;
   endtask

   task automatic expect_all(input string name, input logic e_ack, input logic e_dreq,
                             input logic [RV-1:0] e_rdata, input logic [TW-1:0] e_rtag,
                             input logic e_rerr);
      check({name, ".addr_ack"}, 64'(addr_ack), 64'(e_ack));
      check({name, ".data_req"}, 64'(data_req), 64'(e_dreq));
      check({name, ".rdata"}, rdata, e_rdata);
      check({name, ".rtag"}, 64'(rtag), 64'(e_rtag));
      check({name, ".rerr"}, 64'(rerr), 64'(e_rerr));
   endtask

   initial begin
      // ---------------- reset ----------------
      drive(1'b1, 1'b1, '0, 1'b1, 4'd1, 1'b0);
      tick();
      drive(1'b1, 1'b1, '0, 1'b1, 4'd1, 1'b0);
      check("reset.addr_ack_gated", 64'(addr_ack), 64'd0);
      tick();
      reset = 1'b0;
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      expect_all("reset", 1'b0, 1'b0, '0, '0, 1'b0);

      // ---------------- table-driven vectors ----------------
      vt[0]  = '{1'b0, 1'b0, 13'h000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 64'h0, 4'h0, 1'b0};
      vt[1]  = '{1'b1, 1'b1, 13'h008, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 64'h0, 4'h0, 1'b0};
      vt[2]  = '{1'b0, 1'b0, 13'h000, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, rom_w(1), 4'h3, 1'b0};
      vt[3]  = '{1'b0, 1'b0, 13'h000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 64'h0, 4'h0, 1'b0};
      vt[4]  = '{1'b1, 1'b0, 13'h010, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 64'h0, 4'h0, 1'b0};
      vt[5]  = '{1'b1, 1'b1, 13'h1000, 1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 64'h0, 4'h0, 1'b0};
      vt[6]  = '{1'b0, 1'b0, 13'h000, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 64'h0, 4'h5, 1'b1};
      vt[7]  = '{1'b1, 1'b1, 13'h010, 1'b0, 4'h2, 1'b0, 1'b1, 1'b0, 64'h0, 4'h0, 1'b0};
      vt[8]  = '{1'b0, 1'b0, 13'h000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 64'h0, 4'h0, 1'b0};
      vt[9]  = '{1'b1, 1'b1, 13'h0FF8, 1'b1, 4'h7, 1'b0, 1'b1, 1'b0, 64'h0, 4'h0, 1'b0};
      vt[10] = '{1'b1, 1'b1, 13'h00D, 1'b1, 4'h9, 1'b1, 1'b1, 1'b1, rom_w(511), 4'h7, 1'b0};
      vt[11] = '{1'b1, 1'b1, 13'h018, 1'b1, 4'hA, 1'b1, 1'b1, 1'b1, rom_w(1), 4'h9, 1'b0};
      vt[12] = '{1'b0, 1'b0, 13'h000, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, rom_w(3), 4'hA, 1'b0};
      vt[13] = '{1'b0, 1'b0, 13'h000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 64'h0, 4'h0, 1'b0};
      vt[14] = '{1'b1, 1'b1, 13'h1FF8, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 64'h0, 4'h0, 1'b0};
      vt[15] = '{1'b0, 1'b0, 13'h000, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 64'h0, 4'hF, 1'b1};
      vt[16] = '{1'b0, 1'b0, 13'h000, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 64'h0, 4'h0, 1'b0};

      for (int i = 0; i < 17; i++) begin
         drive(vt[i].areq, vt[i].sel, vt[i].addr, vt[i].rd, vt[i].tag, vt[i].dack);
         expect_all($sformatf("vec%0d", i), vt[i].e_ack, vt[i].e_dreq,
                    vt[i].e_rdata, vt[i].e_rtag, vt[i].e_rerr);
         tick();
      end

      // ---------------- five reads into a depth-4 queue ----------------
      for (int t = 0; t < 4; t++) begin
         drive(1'b1, 1'b1, 13'(t * 8), 1'b1, 4'(t), 1'b0);
         check($sformatf("fill.ack%0d", t), 64'(addr_ack), 64'd1);
         tick();
      end
      drive(1'b1, 1'b1, 13'h020, 1'b1, 4'd4, 1'b0);
      check("full.held_off", 64'(addr_ack), 64'd0);
      tick();
      drive(1'b1, 1'b1, 13'h020, 1'b1, 4'd4, 1'b1);
      expect_all("full.pop_accept", 1'b1, 1'b1, rom_w(0), 4'd0, 1'b0);
      tick();
      for (int t = 1; t < 5; t++) begin
         drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
         expect_all($sformatf("drain%0d", t), 1'b0, 1'b1, rom_w(t), 4'(t), 1'b0);
         tick();
      end
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      check("drain.empty", 64'(data_req), 64'd0);

      // ---------------- full queue with push and pop every cycle ----------------
      for (int t = 0; t < 4; t++) begin
         drive(1'b1, 1'b1, 13'((10 + t) * 8), 1'b1, 4'(t), 1'b0);
         tick();
      end
      for (int j = 0; j < 8; j++) begin
         drive(1'b1, 1'b1, 13'((14 + j) * 8), 1'b1, 4'(4 + j), 1'b1);
         expect_all($sformatf("stream%0d", j), 1'b1, 1'b1, rom_w(10 + j), 4'(j), 1'b0);
         tick();
      end
      for (int j = 8; j < 12; j++) begin
         drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
         expect_all($sformatf("stream_drain%0d", j), 1'b0, 1'b1, rom_w(10 + j), 4'(j), 1'b0);
         tick();
      end
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      check("stream.empty", 64'(data_req), 64'd0);

      // ---------------- reset with responses queued ----------------
      for (int t = 1; t < 4; t++) begin
         drive(1'b1, 1'b1, 13'(64 + t * 8), 1'b1, 4'(t), 1'b0);
         tick();
      end
      reset = 1'b1;
      drive(1'b1, 1'b1, 13'h000, 1'b1, 4'd5, 1'b0);
      check("midreset.ack_gated", 64'(addr_ack), 64'd0);
      tick();
      reset = 1'b0;
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      expect_all("midreset.flushed", 1'b0, 1'b0, '0, '0, 1'b0);
      drive(1'b1, 1'b1, 13'h020, 1'b1, 4'd6, 1'b0);
      check("postreset.ack", 64'(addr_ack), 64'd1);
      tick();
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      expect_all("postreset.head", 1'b0, 1'b1, rom_w(4), 4'd6, 1'b0);
      tick();
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      check("postreset.empty", 64'(data_req), 64'd0);

      // ---------------- random stress against a reference queue ----------------
      begin
         logic [RV-1:0] qd[$];
         logic [TW-1:0] qt[$];
         logic          qe[$];
         logic          r_areq, r_sel, r_rd, r_dack, e_ack, e_pop;
         logic [AW-1:0] r_addr;
         logic [TW-1:0] r_tag;
         int            widx;
         for (int c = 0; c < 300; c++) begin
            r_areq = ($urandom_range(0, 3) != 0);
            r_sel  = ($urandom_range(0, 3) != 0);
            r_rd   = ($urandom_range(0, 4) != 0);
            r_dack = ($urandom_range(0, 2) == 0);
            r_addr = 13'($urandom);
            r_tag  = 4'($urandom);
            drive(r_areq, r_sel, r_addr, r_rd, r_tag, r_dack);
            e_pop = (qd.size() > 0) && r_dack;
            e_ack = r_areq && r_sel && (!r_rd || qd.size() < DEPTH || e_pop);
            if (qd.size() > 0)
               expect_all($sformatf("rand%0d", c), e_ack, 1'b1, qd[0], qt[0], qe[0]);
            else
               expect_all($sformatf("rand%0d", c), e_ack, 1'b0, '0, '0, 1'b0);
            tick();
            if (e_pop) begin
               void'(qd.pop_front());
               void'(qt.pop_front());
               void'(qe.pop_front());
            end
            if (e_ack && r_rd) begin
               widx = int'(r_addr >> 3);
               qd.push_back((widx < ROM_WORDS) ? rom_w(widx) : 64'h0);
               qt.push_back(r_tag);
               qe.push_back(widx >= ROM_WORDS);
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
